arm_fetch_unit: RTL and testbench

Instruction fetch stage for the single-cycle ARM core, directly upstream of the instruction memory. It holds the program counter and drives the word address into the combinational-read instruction memory. It captures each returned instruction word, with the PC it came from, into a small prefetch queue. Decode drains the queue through a valid/ready handshake; a taken branch redirects the PC and flushes the queue.

---
 rtl/arm_fetch_pkg.sv | 22 ++
 rtl/arm_fetch_queue.sv | 76 +++++++
 rtl/arm_fetch_unit.sv | 89 ++++++++
 tb/tb_arm_fetch_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/arm_fetch_pkg.sv
// Shared types and constants for the ARM instruction fetch stage.
// Optional feature macro: ARM_FETCH_ALIGN_CHECK_EN (see arm_fetch_unit).
package arm_fetch_pkg;

  localparam int unsigned BUS_W = 32;

  typedef struct packed {
    logic [BUS_W-1:0] instr;
    logic [BUS_W-1:0] pc;
  } fetch_entry_t;

  localparam logic [BUS_W-1:0] PC_INCR      = 32'd4;
  localparam logic [BUS_W-1:0] R15_OFFSET   = 32'd8;
  localparam logic [BUS_W-1:0] ALIGN_MASK   = 32'hFFFF_FFFC;
  localparam logic [BUS_W-1:0] RESET_VECTOR = 32'h0000_0000;

  // Force a byte address onto a word boundary.
  function automatic logic [BUS_W-1:0] align_addr(input logic [BUS_W-1:0] addr);
    return addr & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/arm_fetch_queue.sv
// Circular prefetch FIFO of fetch entries. The head is kept in a register that
// is loaded with the post-edge head, so it holds its last value when empty.
// Flush has priority over push and pop.
module ARM_FetchQueue
  import arm_fetch_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_data,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int unsigned PW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CW = $clog2(Depth + 1);
  localparam logic [PW-1:0] PtrOne = PW'(1);

  fetch_entry_t mem_q [Depth];
  fetch_entry_t head_q, head_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d, remain;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(Depth));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);
  assign remain  = count_q - CW'(do_pop);
  assign head    = head_q;

  // Next pointers, occupancy and the head value visible after this edge.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrOne;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
      // Nothing left behind the pop: the new head is the entry being written now.
      if (count_d != '0) head_d = (remain == '0) ? push_data : mem_q[rd_ptr_d];
    end
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  // Entry storage; contents are only meaningful under count_q.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/arm_fetch_unit.sv
// Instruction fetch stage: PC register, prefetch queue, branch redirect.
// Define ARM_FETCH_ALIGN_CHECK_EN to trap misaligned branch targets with a
// sticky o_Fetch_Fault; otherwise target bits [1:0] are silently cleared.
module arm_fetch_unit
  import arm_fetch_pkg::*;
#(
  parameter int unsigned          BusWidth    = 32,
  parameter int unsigned          QueueDepth  = 2,
  parameter logic [BusWidth-1:0]  ResetVector = RESET_VECTOR
) (
  input  logic                i_CLK,
  input  logic                i_RESET,
  output logic [BusWidth-1:0] o_Instr_Address,
  input  logic [BusWidth-1:0] i_Instr,
  output logic                o_Valid,
  input  logic                i_Ready,
  output logic [BusWidth-1:0] o_Instr,
  output logic [BusWidth-1:0] o_Instr_PC,
  output logic [BusWidth-1:0] o_PC_Plus8,
  input  logic                i_Branch_Taken,
  input  logic [BusWidth-1:0] i_Branch_Target,
  output logic                o_Fetch_Fault
);

  logic [BusWidth-1:0] pc_q;
  logic                q_full, q_empty;
  logic                deq, enq, redirect, fetch_stop;
  fetch_entry_t        q_head, q_in;

`ifdef ARM_FETCH_ALIGN_CHECK_EN
  logic fault_q;

  // Once faulted, redirects are ignored and fetch stays parked until reset.
  assign redirect   = i_Branch_Taken && !fault_q;
  assign fetch_stop = fault_q;

  // Sticky fault on a redirect to a non-word-aligned target.
  always_ff @(posedge i_CLK or negedge i_RESET) begin
    if (!i_RESET) begin
      fault_q <= 1'b0;
    end else if (redirect && (i_Branch_Target[1:0] != 2'b00)) begin
      fault_q <= 1'b1;
    end
  end

  assign o_Fetch_Fault = fault_q;
`else
  assign redirect      = i_Branch_Taken;
  assign fetch_stop    = 1'b0;
  assign o_Fetch_Fault = 1'b0;
`endif

  assign deq  = o_Valid && i_Ready;
  // A pop this cycle frees a slot for the word being fetched now.
  assign enq  = !redirect && !fetch_stop && (!q_full || deq);
  assign q_in = '{instr: i_Instr, pc: pc_q};

  // Program counter: redirect wins over sequential advance; holds when stalled.
  always_ff @(posedge i_CLK or negedge i_RESET) begin
    if (!i_RESET) begin
      pc_q <= ResetVector;
    end else if (redirect) begin
      pc_q <= align_addr(i_Branch_Target);
    end else if (enq) begin
      pc_q <= pc_q + PC_INCR;
    end
  end

  ARM_FetchQueue #(
    .Depth (QueueDepth)
  ) u_queue (
    .clk       (i_CLK),
    .rst_n     (i_RESET),
    .push      (enq),
    .pop       (deq),
    .flush     (redirect),
    .push_data (q_in),
    .full      (q_full),
    .empty     (q_empty),
    .head      (q_head)
  );

  assign o_Instr_Address = pc_q;
  assign o_Valid         = !q_empty;
  assign o_Instr         = q_head.instr;
  assign o_Instr_PC      = q_head.pc;
  assign o_PC_Plus8      = q_head.pc + R15_OFFSET;

endmodule

// File: tb/tb_arm_fetch_unit.sv
// Self-checking bench for arm_fetch_unit: queue-level reference model checked
// every cycle, plus directed scenarios with literal delivered-PC sequences.
module tb_arm_fetch_unit;

  localparam int unsigned DEPTH = 2;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        ready = 1'b0;
  logic        br    = 1'b0;
  logic [31:0] tgt   = 32'h0;
  logic [31:0] addr, instr_in, out_instr, out_pc, plus8;
  logic        valid, fault;

  int tot = 0;
  int bad = 0;

  always #5 clk = ~clk;

  // Instruction memory: word i holds 0xE000_0000 + i.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hE000_0000 + (a >> 2);
  endfunction

  assign instr_in = mem_word(addr);

  arm_fetch_unit #(
    .BusWidth    (32),
    .QueueDepth  (DEPTH),
    .ResetVector (32'h0)
  ) dut (
    .i_CLK           (clk),
    .i_RESET         (rst_n),
    .o_Instr_Address (addr),
    .i_Instr         (instr_in),
    .o_Valid         (valid),
    .i_Ready         (ready),
    .o_Instr         (out_instr),
    .o_Instr_PC      (out_pc),
    .o_PC_Plus8      (plus8),
    .i_Branch_Taken  (br),
    .i_Branch_Target (tgt),
    .o_Fetch_Fault   (fault)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference model: queue of {instr, pc} entries and a fetch PC.
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t        mq[$];
  ent_t        m_last  = '{instr: 32'h0, pc: 32'h0};
  logic [31:0] m_pc    = 32'h0;
  bit          m_fault = 1'b0;
  bit          m_deq;
  logic [31:0] dut_log[$];
  logic [31:0] m_log[$];
  logic [31:0] exp_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_pc    = 32'h0;
      m_last  = '{instr: 32'h0, pc: 32'h0};
      m_fault = 1'b0;
    end else begin
      m_deq = (mq.size() > 0) && ready;
      if (br && !m_fault) begin
        mq.delete();
        m_pc = {tgt[31:2], 2'b00};
`ifdef ARM_FETCH_ALIGN_CHECK_EN
        if (tgt[1:0] != 2'b00) m_fault = 1'b1;
`endif
      end else begin
        if (m_deq) void'(mq.pop_front());
        if (!m_fault && mq.size() < DEPTH) begin
          mq.push_back('{instr: mem_word(m_pc), pc: m_pc});
          m_pc = m_pc + 32'd4;
        end
      end
      if (mq.size() > 0) m_last = mq[0];
    end
  end

  // Per-cycle compare, away from the active edge; also logs handshakes.
  always @(negedge clk) begin
    chk("valid", valid, (mq.size() > 0));
    chk("instr", out_instr, m_last.instr);
    chk("instr_pc", out_pc, m_last.pc);
    chk("pc_plus8", plus8, m_last.pc + 32'd8);
    chk("addr", addr, m_pc);
    chk("fault", fault, m_fault);
    if (valid && ready) dut_log.push_back(out_pc);
    if ((mq.size() > 0) && ready) m_log.push_back(mq[0].pc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    dut_log.delete();
    m_log.delete();
  endtask

  task automatic check_log(input string nm);
    chk({nm, "_len"}, dut_log.size(), exp_q.size());
    chk({nm, "_mlen"}, m_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < dut_log.size()) chk({nm, "_dut"}, dut_log[i], exp_q[i]);
      if (i < m_log.size())   chk({nm, "_model"}, m_log[i], exp_q[i]);
    end
  endtask

  // Asynchronous reset: outputs must return to reset values immediately.
  task automatic do_reset();
    rst_n = 1'b0;
    br    = 1'b0;
    ready = 1'b0;
    #1;
    chk("rst_valid", valid, 32'h0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_instr_pc", out_pc, 32'h0);
    chk("rst_plus8", plus8, 32'h8);
    chk("rst_addr", addr, 32'h0);
    chk("rst_fault", fault, 32'h0);
    tick();
  endtask

  initial begin
    #1;
    do_reset();

    // Streaming from reset with decode always ready.
    ready = 1'b1;
    rst_n = 1'b1;
    clear_logs();
    tick();
    chk("first_pc", out_pc, 32'h0);
    chk("first_plus8", plus8, 32'h8);
    chk("first_instr", out_instr, 32'hE000_0000);
    repeat (4) tick();
    exp_q = {32'h0, 32'h4, 32'h8, 32'hC};
    check_log("stream");

    // Backpressure from reset (mid-operation reset), then release.
    do_reset();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("bp_addr", addr, 32'h8);
    chk("bp_valid", valid, 32'h1);
    chk("bp_head", out_pc, 32'h0);
    clear_logs();
    ready = 1'b1;
    repeat (4) tick();
    exp_q = {32'h0, 32'h4, 32'h8, 32'hC};
    check_log("bp");

    // Redirect while the queue holds PCs 4 and 8.
    do_reset();
    rst_n = 1'b1;
    repeat (2) tick();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    br    = 1'b1;
    tgt   = 32'h40;
    tick();
    chk("redir_bubble", valid, 32'h0);
    br    = 1'b0;
    ready = 1'b1;
    clear_logs();
    tick();
    chk("redir_target", out_pc, 32'h40);
    repeat (2) tick();
    exp_q = {32'h40, 32'h44};
    check_log("redir");

    // Redirect in the same cycle as dequeue of head 0x10.
    do_reset();
    ready = 1'b1;
    rst_n = 1'b1;
    repeat (5) tick();
    chk("sim_head", out_pc, 32'h10);
    clear_logs();
    br  = 1'b1;
    tgt = 32'h80;
    tick();
    br = 1'b0;
    repeat (2) tick();
    exp_q = {32'h10, 32'h80};
    check_log("sim");

    // Address wrap.
    br  = 1'b1;
    tgt = 32'hFFFF_FFF8;
    tick();
    br = 1'b0;
    clear_logs();
    repeat (4) tick();
    exp_q = {32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
    check_log("wrap");

    // Misaligned target.
    br  = 1'b1;
    tgt = 32'h42;
    tick();
    br = 1'b0;
    clear_logs();
    repeat (3) tick();
`ifdef ARM_FETCH_ALIGN_CHECK_EN
    chk("mis_fault", fault, 32'h1);
    chk("mis_valid", valid, 32'h0);
    chk("mis_addr", addr, 32'h40);
    exp_q = {};
`else
    chk("mis_fault", fault, 32'h0);
    exp_q = {32'h40, 32'h44};
`endif
    check_log("mis");

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
